// File: rtl/uart_pkt_pkg.sv
// Shared definitions for the UART packet parser: parser states, framing
// constants and the widths of the length field and payload address.
package uart_pkt_pkg;

    localparam logic [7:0] HEADER  = 8'hA5;
    localparam int         MAX_LEN = 16;
    localparam int         LEN_W   = 5;
    localparam int         ADDR_W  = 4;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_CMD,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHECK,
        ST_HOLD
    } state_e;

endpackage

// File: rtl/pkt_payload_ram.sv
// 16x8 payload store: one synchronous write port, one registered read port.
module pkt_payload_ram
    import uart_pkt_pkg::*;
(
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              we_in,
    input  logic [ADDR_W-1:0] wr_addr_in,
    input  logic [7:0]        wr_data_in,
    input  logic [ADDR_W-1:0] rd_addr_in,
    output logic [7:0]        rd_data_out
);

    logic [7:0] mem_q [MAX_LEN];
    logic [7:0] rd_data_q;

    always_ff @(posedge clk_in) begin
        if (we_in) begin
            mem_q[wr_addr_in] <= wr_data_in;
        end
    end

    // Storage itself is left unreset; only the read register is cleared.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem_q[rd_addr_in];
        end
    end

    assign rd_data_out = rd_data_q;

endmodule

// File: rtl/uart_packet_parser.sv
// Frame parser for A5/CMD/LEN/payload/CHK packets arriving from a UART receiver;
// holds one checksum-correct packet until the consumer accepts it.
module uart_packet_parser
    import uart_pkt_pkg::*;
#(
    parameter int INPUT_CLOCK_FREQ = 100_000_000,
    parameter int TIMEOUT_CYCLES   = 208_320
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              byte_valid_in,
    input  logic [7:0]        byte_in,
    output logic              pkt_valid_out,
    input  logic              pkt_ready_in,
    output logic [7:0]        pkt_cmd_out,
    output logic [LEN_W-1:0]  pkt_len_out,
    input  logic [ADDR_W-1:0] pkt_rd_addr_in,
    output logic [7:0]        pkt_rd_data_out,
    output logic              err_chk_out,
    output logic              err_len_out,
    output logic              err_timeout_out,
    output logic              err_drop_out
);

    localparam int                IDLE_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT_CYCLES);

    if (INPUT_CLOCK_FREQ <= 0 || TIMEOUT_CYCLES <= 0) begin : g_param_check
        $error("uart_packet_parser: clock frequency and timeout must be positive");
    end

    state_e             state_q, state_d;
    logic [7:0]         cmd_q, cmd_d;
    logic [7:0]         xor_q, xor_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [ADDR_W-1:0]  idx_q, idx_d;
    logic [IDLE_W-1:0]  idle_q, idle_d;
    logic               err_chk_q, err_chk_d;
    logic               err_len_q, err_len_d;
    logic               err_to_q, err_to_d;
    logic               err_drop_q, err_drop_d;
    logic               buf_we;
    logic               hunt_byte;
    logic               in_frame;
    logic               timeout;

    assign in_frame = state_q inside {ST_CMD, ST_LEN, ST_PAYLOAD, ST_CHECK};
    assign timeout  = in_frame && (idle_q == IDLE_LIMIT);

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        xor_d      = xor_q;
        len_d      = len_q;
        idx_d      = idx_q;
        idle_d     = '0;
        err_chk_d  = 1'b0;
        err_len_d  = 1'b0;
        err_to_d   = 1'b0;
        err_drop_d = 1'b0;
        buf_we     = 1'b0;
        hunt_byte  = 1'b0;

        if (in_frame && !byte_valid_in) begin
            idle_d = idle_q + 1'b1;
        end

        // Timeout wins over the in-frame byte; that byte is re-read as a hunt byte.
        if (timeout) begin
            err_to_d  = 1'b1;
            idle_d    = '0;
            state_d   = ST_HUNT;
            hunt_byte = 1'b1;
        end else begin
            case (state_q)
                ST_HUNT: hunt_byte = 1'b1;
                ST_CMD: if (byte_valid_in) begin
                    cmd_d   = byte_in;
                    xor_d   = byte_in;
                    state_d = ST_LEN;
                end
                ST_LEN: if (byte_valid_in) begin
                    if (byte_in > 8'(MAX_LEN)) begin
                        err_len_d = 1'b1;
                        state_d   = ST_HUNT;
                    end else begin
                        len_d   = byte_in[LEN_W-1:0];
                        xor_d   = xor_q ^ byte_in;
                        idx_d   = '0;
                        state_d = (byte_in == 8'h00) ? ST_CHECK : ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: if (byte_valid_in) begin
                    buf_we = 1'b1;
                    xor_d  = xor_q ^ byte_in;
                    idx_d  = idx_q + 1'b1;
                    if (LEN_W'(idx_q) == len_q - LEN_W'(1)) begin
                        state_d = ST_CHECK;
                    end
                end
                ST_CHECK: if (byte_valid_in) begin
                    if (byte_in == xor_q) begin
                        state_d = ST_HOLD;
                    end else begin
                        err_chk_d = 1'b1;
                        state_d   = ST_HUNT;
                    end
                end
                ST_HOLD: begin
                    if (pkt_ready_in) begin
                        state_d   = ST_HUNT;
                        hunt_byte = 1'b1;
                    end else if (byte_valid_in) begin
                        err_drop_d = 1'b1;
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end

        if (hunt_byte && byte_valid_in && byte_in == HEADER) begin
            state_d = ST_CMD;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q    <= ST_HUNT;
            cmd_q      <= '0;
            xor_q      <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            idle_q     <= '0;
            err_chk_q  <= 1'b0;
            err_len_q  <= 1'b0;
            err_to_q   <= 1'b0;
            err_drop_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            xor_q      <= xor_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            idle_q     <= idle_d;
            err_chk_q  <= err_chk_d;
            err_len_q  <= err_len_d;
            err_to_q   <= err_to_d;
            err_drop_q <= err_drop_d;
        end
    end

    pkt_payload_ram u_payload_ram (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .we_in       (buf_we),
        .wr_addr_in  (idx_q),
        .wr_data_in  (byte_in),
        .rd_addr_in  (pkt_rd_addr_in),
        .rd_data_out (pkt_rd_data_out)
    );

    assign pkt_valid_out   = (state_q == ST_HOLD);
    assign pkt_cmd_out     = cmd_q;
    assign pkt_len_out     = len_q;
    assign err_chk_out     = err_chk_q;
    assign err_len_out     = err_len_q;
    assign err_timeout_out = err_to_q;
    assign err_drop_out    = err_drop_q;

endmodule

// File: tb/tb_uart_packet_parser.sv
// Bench for uart_packet_parser: fixed frame table, directed corner sequences,
// and randomized traffic checked every cycle against a frame-level model.
`timescale 1ns/1ps
module tb_uart_packet_parser;

    localparam int TO = 40;

    logic       clk = 1'b0;
    logic       rst_n, bv, pr;
    logic [7:0] bi;
    logic [3:0] addr;
    logic       pkt_valid, err_chk, err_len, err_to, err_drop;
    logic [7:0] pkt_cmd, rd_data;
    logic [4:0] pkt_len;

    always #5 clk = ~clk;

    uart_packet_parser #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_in          (clk),
        .rst_in          (rst_n),
        .byte_valid_in   (bv),
        .byte_in         (bi),
        .pkt_valid_out   (pkt_valid),
        .pkt_ready_in    (pr),
        .pkt_cmd_out     (pkt_cmd),
        .pkt_len_out     (pkt_len),
        .pkt_rd_addr_in  (addr),
        .pkt_rd_data_out (rd_data),
        .err_chk_out     (err_chk),
        .err_len_out     (err_len),
        .err_timeout_out (err_to),
        .err_drop_out    (err_drop)
    );

    int checks = 0;
    int errors = 0;
    int n_chk = 0, n_len = 0, n_to = 0, n_drop = 0;
    bit rnd = 1'b0;

    // Frame-level reference model
    bit         m_valid, m_infr, m_rst, m_rd_chk;
    bit         e_chk, e_len, e_to, e_drop;
    logic [7:0] m_cmd, m_rd;
    logic [4:0] m_len;
    logic [7:0] m_buf [16];
    int         m_idle;
    logic [7:0] m_frame [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bytes after the header; frame completes when CMD+LEN+payload+CHK are in.
    task automatic consume(input logic [7:0] b);
        logic [7:0] x;
        int n;
        m_frame.push_back(b);
        n = m_frame.size();
        if (n == 2 && b > 8'd16) begin
            e_len  = 1'b1;
            m_infr = 1'b0;
        end else if (n >= 3 && n == int'(m_frame[1]) + 3) begin
            x = 8'h00;
            for (int i = 0; i < n - 1; i++) x ^= m_frame[i];
            if (b == x) begin
                m_valid = 1'b1;
                m_cmd   = m_frame[0];
                m_len   = 5'(m_frame[1]);
                for (int i = 0; i < int'(m_len); i++) m_buf[i] = m_frame[2 + i];
            end else begin
                e_chk = 1'b1;
            end
            m_infr = 1'b0;
        end
    endtask

    task automatic model_step(input logic rn, input logic v, input logic [7:0] b,
                              input logic r, input logic [3:0] a);
        bit start;
        start = 1'b0;
        e_chk = 1'b0; e_len = 1'b0; e_to = 1'b0; e_drop = 1'b0;
        m_rst = !rn;
        if (!rn) begin
            m_valid = 1'b0; m_infr = 1'b0; m_idle = 0;
            m_cmd = 8'h00; m_len = 5'd0; m_rd = 8'h00; m_rd_chk = 1'b1;
            m_frame.delete();
            return;
        end
        m_rd_chk = m_valid && (5'(a) < m_len);
        m_rd     = m_buf[a];
        if (m_valid) begin
            if (r) begin
                m_valid = 1'b0;
                start   = v && b == 8'hA5;
            end else if (v) begin
                e_drop = 1'b1;
            end
        end else if (m_infr) begin
            if (m_idle == TO) begin
                e_to   = 1'b1;
                m_infr = 1'b0;
                start  = v && b == 8'hA5;
            end else if (v) begin
                m_idle = 0;
                consume(b);
            end else begin
                m_idle++;
            end
        end else begin
            start = v && b == 8'hA5;
        end
        if (start) begin
            m_infr = 1'b1;
            m_idle = 0;
            m_frame.delete();
        end
        if (!m_valid) m_rd_chk = 1'b0;
    endtask

    task automatic tick();
        if (rnd) begin
            pr   = ($urandom_range(0, 3) == 0);
            addr = 4'($urandom_range(0, 15));
        end
        @(posedge clk);
        model_step(rst_n, bv, bi, pr, addr);
        #1;
        check("valid", 32'(pkt_valid), 32'(m_valid));
        check("err_chk", 32'(err_chk), 32'(e_chk));
        check("err_len", 32'(err_len), 32'(e_len));
        check("err_timeout", 32'(err_to), 32'(e_to));
        check("err_drop", 32'(err_drop), 32'(e_drop));
        if (m_valid || m_rst) begin
            check("cmd", 32'(pkt_cmd), 32'(m_cmd));
            check("len", 32'(pkt_len), 32'(m_len));
        end
        if (m_rd_chk) check("rd_data", 32'(rd_data), 32'(m_rd));
        n_chk  += int'(err_chk === 1'b1);
        n_len  += int'(err_len === 1'b1);
        n_to   += int'(err_to === 1'b1);
        n_drop += int'(err_drop === 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic gap();
        if (rnd) idle($urandom_range(0, 2));
    endtask

    task automatic send(input logic [7:0] b);
        bv = 1'b1;
        bi = b;
        tick();
        bv = 1'b0;
        bi = 8'h00;
    endtask

    task automatic release_pkt();
        pr = 1'b1;
        tick();
        pr = 1'b0;
    endtask

    task automatic send_frame(input int len, input bit corrupt);
        logic [7:0] x, c, p;
        c = 8'($urandom);
        x = c ^ 8'(len);
        send(8'hA5); gap();
        send(c); gap();
        send(8'(len)); gap();
        for (int i = 0; i < len; i++) begin
            p = 8'($urandom);
            x ^= p;
            send(p); gap();
        end
        send(corrupt ? (x ^ 8'h01) : x);
    endtask

    typedef struct {
        logic [0:7][7:0] bytes;
        int              n;
        logic            valid;
        logic [7:0]      cmd;
        logic [4:0]      len;
        int              chk;
        int              lerr;
    } vec_t;

    vec_t tbl [6];
    logic [7:0] pay [16];
    logic [7:0] xs;
    int c0, l0, t0, d0;

    initial begin
        tbl[0] = '{64'hA5_01_02_10_20_33_00_00, 6, 1'b1, 8'h01, 5'd2, 0, 0};
        tbl[1] = '{64'hA5_01_02_10_20_34_00_00, 6, 1'b0, 8'h00, 5'd0, 1, 0};
        tbl[2] = '{64'hA5_07_11_00_00_00_00_00, 3, 1'b0, 8'h00, 5'd0, 0, 1};
        tbl[3] = '{64'hA5_07_00_07_00_00_00_00, 4, 1'b1, 8'h07, 5'd0, 0, 0};
        tbl[4] = '{64'h12_34_A5_03_01_5C_5E_00, 7, 1'b1, 8'h03, 5'd1, 0, 0};
        tbl[5] = '{64'hA5_02_01_A5_A6_00_00_00, 5, 1'b1, 8'h02, 5'd1, 0, 0};

        rst_n = 1'b0; bv = 1'b0; bi = 8'h00; pr = 1'b0; addr = 4'd0;
        idle(3);
        check("rst_valid", 32'(pkt_valid), 32'd0);
        check("rst_cmd", 32'(pkt_cmd), 32'd0);
        check("rst_len", 32'(pkt_len), 32'd0);
        check("rst_rd", 32'(rd_data), 32'd0);
        check("rst_errs", 32'({err_chk, err_len, err_to, err_drop}), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            c0 = n_chk; l0 = n_len;
            for (int j = 0; j < tbl[i].n; j++) send(tbl[i].bytes[j]);
            idle(2);
            check($sformatf("vec%0d_valid", i), 32'(pkt_valid), 32'(tbl[i].valid));
            if (tbl[i].valid) begin
                check($sformatf("vec%0d_cmd", i), 32'(pkt_cmd), 32'(tbl[i].cmd));
                check($sformatf("vec%0d_len", i), 32'(pkt_len), 32'(tbl[i].len));
            end
            check($sformatf("vec%0d_chk_cnt", i), 32'(n_chk - c0), 32'(tbl[i].chk));
            check($sformatf("vec%0d_len_cnt", i), 32'(n_len - l0), 32'(tbl[i].lerr));
            if (tbl[i].valid) release_pkt();
        end

        // Payload readback, then backpressure drop and transfer with a header byte
        for (int j = 0; j < 6; j++) send(tbl[0].bytes[j]);
        addr = 4'd0; tick();
        check("read_addr0", 32'(rd_data), 32'h10);
        addr = 4'd1; tick();
        check("read_addr1", 32'(rd_data), 32'h20);
        d0 = n_drop;
        send(8'h55);
        check("drop_cnt", 32'(n_drop - d0), 32'd1);
        check("drop_valid", 32'(pkt_valid), 32'd1);
        check("drop_cmd", 32'(pkt_cmd), 32'h01);
        check("drop_len", 32'(pkt_len), 32'd2);
        tick();
        check("drop_rd", 32'(rd_data), 32'h20);
        pr = 1'b1; bv = 1'b1; bi = 8'hA5;
        tick();
        pr = 1'b0; bv = 1'b0;
        check("xfer_valid", 32'(pkt_valid), 32'd0);
        check("xfer_no_drop", 32'(n_drop - d0), 32'd1);
        send(8'h01); send(8'h00); send(8'h01);
        check("xfer_then_cmd", 32'(pkt_cmd), 32'h01);
        check("xfer_then_valid", 32'(pkt_valid), 32'd1);
        release_pkt();

        // Timeout mid-frame, then trailing bytes must be ignored
        t0 = n_to;
        send(8'hA5); send(8'h01);
        idle(TO + 3);
        check("timeout_cnt", 32'(n_to - t0), 32'd1);
        send(8'h07); send(8'h00); send(8'h07);
        idle(2);
        check("timeout_hunt", 32'(pkt_valid), 32'd0);

        // Header arriving on the very cycle the timeout fires starts a new frame
        t0 = n_to;
        send(8'hA5); send(8'h01);
        idle(TO);
        send(8'hA5);
        check("timeout_same_cnt", 32'(n_to - t0), 32'd1);
        send(8'h05); send(8'h00); send(8'h05);
        check("timeout_same_valid", 32'(pkt_valid), 32'd1);
        check("timeout_same_cmd", 32'(pkt_cmd), 32'h05);
        release_pkt();

        // Maximum-length payload, read back in full
        xs = 8'h3C ^ 8'h10;
        send(8'hA5); send(8'h3C); send(8'h10);
        for (int i = 0; i < 16; i++) begin
            pay[i] = 8'(i * 7 + 3);
            xs ^= pay[i];
            send(pay[i]);
        end
        send(xs);
        check("max_valid", 32'(pkt_valid), 32'd1);
        check("max_len", 32'(pkt_len), 32'd16);
        for (int i = 0; i < 16; i++) begin
            addr = 4'(i);
            tick();
            check($sformatf("max_rd%0d", i), 32'(rd_data), 32'(pay[i]));
        end
        release_pkt();

        // Reset mid-payload abandons the frame silently
        send(8'hA5); send(8'h01); send(8'h04); send(8'hAA);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_valid", 32'(pkt_valid), 32'd0);
        check("midrst_cmd", 32'(pkt_cmd), 32'd0);
        check("midrst_len", 32'(pkt_len), 32'd0);
        check("midrst_rd", 32'(rd_data), 32'd0);
        check("midrst_errs", 32'({err_chk, err_len, err_to, err_drop}), 32'd0);
        for (int j = 0; j < 6; j++) send(tbl[0].bytes[j]);
        check("postrst_valid", 32'(pkt_valid), 32'd1);
        check("postrst_cmd", 32'(pkt_cmd), 32'h01);
        check("postrst_len", 32'(pkt_len), 32'd2);
        release_pkt();

        // Randomized traffic against the model
        rnd = 1'b1;
        for (int it = 0; it < 300; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: send_frame($urandom_range(0, 16), 1'b0);
                5:             send_frame($urandom_range(0, 16), 1'b1);
                6: begin
                    send(8'hA5); gap(); send(8'($urandom)); gap();
                    send(8'($urandom_range(17, 255)));
                end
                7: send(8'($urandom));
                8: begin
                    send(8'hA5); send(8'($urandom)); send(8'($urandom_range(1, 16)));
                    idle(TO + $urandom_range(0, 4));
                end
                default: idle($urandom_range(1, 6));
            endcase
            gap();
        end
        rnd = 1'b0;
        pr = 1'b1;
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
